// File: rtl/opicorv32_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module : opicorv32_exec_pkg
// Brief  : Shared types and constants for the execute/writeback sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package opicorv32_exec_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_SLL    = 3'd2;
  localparam logic [2:0] OP_SRL    = 3'd3;
  localparam logic [2:0] OP_SRA    = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_BRANCH = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  function automatic logic is_shift(input logic [2:0] kind);
    return (kind == OP_SLL) || (kind == OP_SRL) || (kind == OP_SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/opicorv32_exec_wb_if.sv
`default_nettype none
// ============================================================================
// Module : opicorv32_exec_wb_if
// Brief  : Issue, writeback and branch-resolution bundle of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface opicorv32_exec_wb_if;
  import opicorv32_exec_pkg::*;

  logic            start;
  logic [2:0]      op_kind;
  logic [XLEN-1:0] reg_op1;
  logic [XLEN-1:0] reg_op2;
  logic [XLEN-1:0] alu_out;
  logic            alu_out_0;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic            busy;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            br_valid;
  logic            br_taken;
  logic [XLEN-1:0] br_target;

  modport slave (
    input  start, op_kind, reg_op1, reg_op2, alu_out, alu_out_0, pc, imm, rd,
    input  wb_ready,
    output busy, wb_valid, wb_rd, wb_data, br_valid, br_taken, br_target
  );

  modport master (
    output start, op_kind, reg_op1, reg_op2, alu_out, alu_out_0, pc, imm, rd,
    output wb_ready,
    input  busy, wb_valid, wb_rd, wb_data, br_valid, br_taken, br_target
  );

endinterface
`default_nettype wire

// File: rtl/opicorv32_shift_step.sv
`default_nettype none
// ============================================================================
// Module : opicorv32_shift_step
// Brief  : Combinational shifter by a variable amount (SLL/SRL/SRA).
// Rev    : 1.0  initial release
// ============================================================================
module opicorv32_shift_step
  import opicorv32_exec_pkg::*;
(
  input  logic [XLEN-1:0] value,
  input  logic            left,
  input  logic            arith,
  input  logic [4:0]      amount,
  output logic [XLEN-1:0] shifted
);

  always_comb begin
    shifted = value;
    if (left) begin
      shifted = value << amount;
    end else if (arith) begin
      shifted = $unsigned($signed(value) >>> amount);
    end else begin
      shifted = value >> amount;
    end
  end

endmodule
`default_nettype wire

// File: rtl/opicorv32_exec_wb.sv
`default_nettype none
// ============================================================================
// Module : opicorv32_exec_wb
// Brief  : Execute/writeback sequencer behind opicorv32_alu: shifts, branch
//          resolution and valid/ready register-file writeback.
//          Build option: OPICORV32_TWO_STAGE_SHIFT_EN (4/1-bit shift steps).
// Rev    : 1.0  initial release
// ============================================================================
module opicorv32_exec_wb
  import opicorv32_exec_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  opicorv32_exec_wb_if.slave  bus
);

`ifdef OPICORV32_TWO_STAGE_SHIFT_EN
  localparam bit MULTI_STEP = 1'b1;
`else
  localparam bit MULTI_STEP = 1'b0;
`endif

  state_e          state_q,  state_d;
  logic [4:0]      rd_q,     rd_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic [XLEN-1:0] imm_q,    imm_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            cmp_q,    cmp_d;
  logic [4:0]      cnt_q,    cnt_d;
  logic            shl_q,    shl_d;
  logic            sra_q,    sra_d;

  logic [4:0]      step_amt;
  logic [XLEN-1:0] shifted;
  logic            wb_req;
  logic            unused_op2_hi;

  // Only the low five bits of reg_op2 form the shift amount.
  assign unused_op2_hi = ^bus.reg_op2[XLEN-1:5];

  always_comb begin
    step_amt = cnt_q;
    if (MULTI_STEP) begin
      if (cnt_q >= 5'd4) begin
        step_amt = 5'd4;
      end else if (cnt_q != 5'd0) begin
        step_amt = 5'd1;
      end else begin
        step_amt = 5'd0;
      end
    end
  end

  opicorv32_shift_step u_shift_step (
    .value   (result_q),
    .left    (shl_q),
    .arith   (sra_q),
    .amount  (step_amt),
    .shifted (shifted)
  );

  assign wb_req = (state_q == ST_WB) && (rd_q != 5'd0);

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    result_d = result_q;
    cmp_d    = cmp_q;
    cnt_d    = cnt_q;
    shl_d    = shl_q;
    sra_d    = sra_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          rd_d     = bus.rd;
          pc_d     = bus.pc;
          imm_d    = bus.imm;
          cmp_d    = bus.alu_out_0;
          cnt_d    = bus.reg_op2[4:0];
          shl_d    = (bus.op_kind == OP_SLL);
          sra_d    = (bus.op_kind == OP_SRA);
          result_d = is_shift(bus.op_kind) ? bus.reg_op1 : bus.alu_out;
          if (is_shift(bus.op_kind)) begin
            state_d = ST_SHIFT;
          end else if (bus.op_kind == OP_BRANCH) begin
            state_d = ST_BRANCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt_q != 5'd0) begin
          result_d = shifted;
          cnt_d    = cnt_q - step_amt;
        end
        // The single-cycle build finishes the whole shift on entry.
        if ((cnt_q == 5'd0) || !MULTI_STEP) begin
          state_d = ST_WB;
        end
      end
      ST_BRANCH: begin
        state_d = ST_IDLE;
      end
      ST_WB: begin
        if ((rd_q == 5'd0) || bus.wb_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rd_q     <= 5'd0;
      pc_q     <= '0;
      imm_q    <= '0;
      result_q <= '0;
      cmp_q    <= 1'b0;
      cnt_q    <= 5'd0;
      shl_q    <= 1'b0;
      sra_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      result_q <= result_d;
      cmp_q    <= cmp_d;
      cnt_q    <= cnt_d;
      shl_q    <= shl_d;
      sra_q    <= sra_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.wb_valid  = wb_req;
  assign bus.wb_rd     = rd_q;
  assign bus.wb_data   = result_q;
  assign bus.br_valid  = (state_q == ST_BRANCH);
  assign bus.br_taken  = (state_q == ST_BRANCH) && cmp_q;
  assign bus.br_target = pc_q + imm_q;

endmodule
`default_nettype wire

// File: tb/tb_opicorv32_exec_wb.sv
`default_nettype none
// ============================================================================
// Module : tb_opicorv32_exec_wb
// Brief  : Directed self-checking bench for opicorv32_exec_wb.
// Rev    : 1.0  initial release
// ============================================================================
module tb_opicorv32_exec_wb;

  logic clock;
  logic reset;
  int   passed;
  int   total;
  int   n;

  opicorv32_exec_wb_if bus ();

  opicorv32_exec_wb dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
    check({tag, "_wb_valid"},  {31'd0, bus.wb_valid},  32'd0);
    check({tag, "_br_valid"},  {31'd0, bus.br_valid},  32'd0);
    check({tag, "_br_taken"},  {31'd0, bus.br_taken},  32'd0);
    check({tag, "_wb_rd"},     {27'd0, bus.wb_rd},     32'd0);
    check({tag, "_wb_data"},   bus.wb_data,            32'd0);
    check({tag, "_br_target"}, bus.br_target,          32'd0);
  endtask

  task automatic issue(input logic [2:0] kind, input logic [31:0] op1, input logic [31:0] op2,
                       input logic [31:0] alu, input logic cmp, input logic [31:0] pcv,
                       input logic [31:0] immv, input logic [4:0] rdv);
    bus.start     = 1'b1;
    bus.op_kind   = kind;
    bus.reg_op1   = op1;
    bus.reg_op2   = op2;
    bus.alu_out   = alu;
    bus.alu_out_0 = cmp;
    bus.pc        = pcv;
    bus.imm       = immv;
    bus.rd        = rdv;
    tick();
    bus.start     = 1'b0;
  endtask

  function automatic int shift_cycles(input int sh);
`ifdef OPICORV32_TWO_STAGE_SHIFT_EN
    return sh / 4 + sh % 4 + 1;
`else
    return (sh >= 0) ? 1 : 1;
`endif
  endfunction

  // Issues a shift with wb_ready high and checks occupancy, result and release.
  task automatic run_shift(input string tag, input logic [2:0] kind, input logic [31:0] op1,
                           input logic [31:0] op2, input logic [4:0] rdv,
                           input logic [31:0] exp_data);
    int cyc;
    bus.wb_ready = 1'b1;
    issue(kind, op1, op2, 32'h5A5A_5A5A, 1'b0, 32'h0, 32'h0, rdv);
    cyc = 0;
    while (!bus.wb_valid && cyc < 64) begin
      cyc++;
      tick();
    end
    check({tag, "_cycles"}, cyc, shift_cycles(int'(op2[4:0])));
    check({tag, "_data"},   bus.wb_data, exp_data);
    check({tag, "_rd"},     {27'd0, bus.wb_rd}, {27'd0, rdv});
    tick();
    check({tag, "_idle"},   {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op_kind   = 3'd0;
    bus.reg_op1   = '0;
    bus.reg_op2   = '0;
    bus.alu_out   = '0;
    bus.alu_out_0 = 1'b0;
    bus.pc        = '0;
    bus.imm       = '0;
    bus.rd        = '0;
    bus.wb_ready  = 1'b1;
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // ALU with a real destination
    issue(3'd0, 32'h0, 32'h0, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 5'd5);
    check("alu_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("alu_wb_rd",    {27'd0, bus.wb_rd},    32'd5);
    check("alu_wb_data",  bus.wb_data,           32'h1234_5678);
    check("alu_busy",     {31'd0, bus.busy},     32'd1);
    tick();
    check("alu_busy_fall", {31'd0, bus.busy},     32'd0);
    check("alu_wb_drop",   {31'd0, bus.wb_valid}, 32'd0);

    // ALU to x0: no writeback, one busy cycle
    issue(3'd6, 32'h0, 32'h0, 32'hAAAA_0001, 1'b0, 32'h0, 32'h0, 5'd0);
    check("x0_busy",     {31'd0, bus.busy},     32'd1);
    check("x0_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    tick();
    check("x0_busy_fall", {31'd0, bus.busy},     32'd0);
    check("x0_wb_after",  {31'd0, bus.wb_valid}, 32'd0);

    // Shifts
    run_shift("sra31", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF);
    run_shift("srl5",  3'd3, 32'h8000_0000, 32'h0000_0005, 5'd3,  32'h0400_0000);
    run_shift("sll0",  3'd2, 32'h0000_ABCD, 32'h0000_0020, 5'd2,  32'h0000_ABCD);
    run_shift("sll13", 3'd2, 32'h0000_000F, 32'h0000_000D, 5'd12, 32'h0001_E000);
    run_shift("sra6",  3'd4, 32'h7000_0000, 32'h0000_0006, 5'd4,  32'h01C0_0000);

    // Branch taken with negative offset
    issue(3'd1, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0000_0100, 32'hFFFF_FFF0, 5'd9);
    check("br_valid",     {31'd0, bus.br_valid}, 32'd1);
    check("br_taken",     {31'd0, bus.br_taken}, 32'd1);
    check("br_target",    bus.br_target,         32'h0000_00F0);
    check("br_no_wb",     {31'd0, bus.wb_valid}, 32'd0);
    tick();
    check("br_pulse_end", {31'd0, bus.br_valid}, 32'd0);
    check("br_idle",      {31'd0, bus.busy},     32'd0);
    check("br_no_wb2",    {31'd0, bus.wb_valid}, 32'd0);

    // Branch not taken, target wraps past 2^32
    issue(3'd1, 32'h0, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFF8, 32'h0000_0010, 5'd1);
    check("brn_valid",  {31'd0, bus.br_valid}, 32'd1);
    check("brn_taken",  {31'd0, bus.br_taken}, 32'd0);
    check("brn_target", bus.br_target,         32'h0000_0008);
    tick();

    // Backpressure with ignored start pulses while busy
    bus.wb_ready = 1'b0;
    issue(3'd2, 32'h0000_0001, 32'h0000_0004, 32'h0, 1'b0, 32'h0, 32'h0, 5'd10);
    bus.start   = 1'b1;
    bus.op_kind = 3'd0;
    bus.alu_out = 32'hDEAD_BEEF;
    bus.rd      = 5'd21;
    n = 0;
    while (!bus.wb_valid && n < 64) begin
      n++;
      tick();
    end
    check("bp_reach_wb", {31'd0, bus.wb_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.start = i[0];
      check("bp_hold_valid", {31'd0, bus.wb_valid}, 32'd1);
      check("bp_hold_data",  bus.wb_data,           32'h0000_0010);
      check("bp_hold_rd",    {27'd0, bus.wb_rd},    32'd10);
      tick();
    end
    bus.start    = 1'b0;
    bus.wb_ready = 1'b1;
    check("bp_accept_data", bus.wb_data, 32'h0000_0010);
    tick();
    check("bp_done_busy",  {31'd0, bus.busy},     32'd0);
    check("bp_done_valid", {31'd0, bus.wb_valid}, 32'd0);

    // Back-to-back start right after the handshake
    issue(3'd0, 32'h0, 32'h0, 32'h0000_0055, 1'b0, 32'h0, 32'h0, 5'd1);
    check("b2b_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("b2b_data",  bus.wb_data,           32'h0000_0055);
    tick();

    // Reset during SHIFT aborts the instruction
    bus.wb_ready = 1'b0;
    issue(3'd4, 32'h8000_0000, 32'h0000_001F, 32'h0, 1'b1, 32'h0000_1000, 32'h0000_0020, 5'd17);
    check("mid_in_shift", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    reset = 1'b0;
    tick();
    check("mid_no_wb", {31'd0, bus.wb_valid}, 32'd0);
    bus.wb_ready = 1'b1;
    issue(3'd0, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 5'd31);
    check("post_valid", {31'd0, bus.wb_valid}, 32'd1);
    check("post_data",  bus.wb_data,           32'hCAFE_F00D);
    check("post_rd",    {27'd0, bus.wb_rd},    32'd31);
    tick();
    check("post_idle",  {31'd0, bus.busy},     32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/opicorv32_exec_wb.md
# opicorv32_exec_wb

Execute/writeback sequencer directly downstream of the combinational `opicorv32_alu`. It samples `alu_out`/`alu_out_0` on instruction start, runs the shift operations the ALU does not implement, and resolves branches into a taken flag plus target. It then presents the result to the register file over a valid/ready writeback handshake.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin one instruction; accepted only when `busy`=0.
- `op_kind`  in  3  0=ALU, 1=BRANCH, 2=SLL, 3=SRL, 4=SRA; 5..7 are treated as ALU.
- `reg_op1`  in  32  shift source operand.
- `reg_op2`  in  32  shift amount in `[4:0]`.
- `alu_out`  in  32  ALU result, sampled on the start cycle.
- `alu_out_0`  in  1  ALU compare bit, sampled on the start cycle.
- `pc`  in  32  instruction PC.
- `imm`  in  32  branch offset.
- `rd`  in  5  destination register.
- `busy`  out  1  an instruction is in flight.
- `wb_valid`  out  1  writeback request.
- `wb_ready`  in  1  register file accepts the writeback.
- `wb_rd`  out  5  writeback register index.
- `wb_data`  out  32  writeback value.
- `br_valid`  out  1  one-cycle branch-resolution pulse.
- `br_taken`  out  1  branch taken.
- `br_target`  out  32  `pc + imm`, modulo 2^32.

## Operation
- States: IDLE, SHIFT, BRANCH, WB.
- IDLE with `start`=1 captures `rd`, `pc`, `imm`, `alu_out` (into `result`), `alu_out_0`, `reg_op1` (into `result` for shifts) and `reg_op2[4:0]` (into `cnt`).
- Next state from IDLE:
  - ALU: WB.
  - BRANCH: BRANCH.
  - SLL/SRL/SRA: SHIFT.
- SHIFT: advance per the Configuration section. When `cnt`=0, go to WB.
  - SRA replicates bit 31.
  - SRL and SLL fill with zeros.
- BRANCH: assert `br_valid` for one cycle with `br_taken`=captured `alu_out_0` and `br_target`=`pc+imm`. Then go to IDLE. No writeback.
- WB when `rd`=0: no `wb_valid`; go to IDLE the same cycle.
- WB when `rd`≠0: `wb_valid`=1, `wb_rd`/`wb_data`=captured values. Go to IDLE on the cycle `wb_valid && wb_ready`.
- `busy` = state≠IDLE.

## Timing
- Reset values:
  - state=IDLE.
  - `busy`, `wb_valid`, `br_valid`, `br_taken` = 0.
  - `wb_rd`=0, `wb_data`=0, `br_target`=0.
- Reset mid-operation aborts the instruction. All outputs return to reset values at the next edge, and no partial writeback is issued.
- `start` while `busy`=1 is ignored; no queueing.
- ALU op: `wb_valid` rises 1 cycle after `start`. With `wb_ready` held at 1, `busy` falls after 2 cycles.
- Branch: `br_valid` is high in the cycle after `start`.
- While `wb_valid`=1 and `wb_ready`=0, `wb_rd`/`wb_data` hold stable. `wb_valid` never drops without a handshake.
- A new `start` may arrive in the cycle `busy`=0 directly following the handshake.

## Configuration
- `OPICORV32_TWO_STAGE_SHIFT_EN` defined: each SHIFT cycle shifts by 4 if `cnt`≥4 (`cnt`-=4), else by 1 if `cnt`>0 (`cnt`-=1). The state exits when `cnt`=0.
  - SHIFT occupancy = floor(sh/4) + (sh mod 4) + 1 cycles.
- Macro undefined: SHIFT performs the full barrel shift in one cycle, then goes to WB.
  - SHIFT occupancy = 1 cycle for any amount.

## Structure
- Package `opicorv32_exec_pkg`: `op_kind` encoding constants, state enum, `XLEN`.
- Sub-module `opicorv32_shift_step`: combinational. Inputs are value, direction, arithmetic flag and step amount; output is the shifted value. It is used by both configurations.

## Test plan
- ALU, `alu_out`=0x1234_5678, `rd`=5, `wb_ready`=1 -> `wb_valid` one cycle after `start` with `wb_rd`=5, `wb_data`=0x1234_5678; `busy` falls after 2 cycles.
- ALU with `rd`=0 -> `wb_valid` never asserts; `busy` high for exactly 1 cycle.
- SRA, `reg_op1`=0x8000_0000, shamt 31, macro defined -> `wb_data`=0xFFFF_FFFF after 7+3+1=11 SHIFT cycles. Macro undefined -> 1 SHIFT cycle.
- BRANCH, `alu_out_0`=1, `pc`=0x100, `imm`=0xFFFF_FFF0 -> one-cycle `br_valid` with `br_taken`=1, `br_target`=0xF0; no `wb_valid`.
- Backpressure: SLL 0x1 by 4 with `wb_ready`=0 for 5 cycles -> `wb_data`=0x10 held stable throughout, then accepted; `start` pulses during `busy` are ignored.
- `reset` asserted mid-SHIFT -> all outputs at reset values next edge; a subsequent ALU op completes normally.
